// File: rtl/miter_mon_pkg.sv
// Shared types and limits for the sequential miter monitor.
package miter_mon_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} mon_state_e;

   localparam int MAX_GATE_LAT = 7;

endpackage

// File: rtl/miter_align_pipe.sv
// Delays valid and gold by DEPTH cycles so they line up with the gate output.
// DEPTH=0 is a pure wire; flush drops every in-flight valid, including the one entering.
module miter_align_pipe #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             vld_in,
   input  logic [WIDTH-1:0] gold_in,
   output logic             vld_out,
   output logic [WIDTH-1:0] gold_out
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset ^ flush;
      assign vld_out     = vld_in;
      assign gold_out    = gold_in;
   end else begin : g_delay
      logic [DEPTH-1:0] vld_p;
      logic [WIDTH-1:0] gold_p [DEPTH];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld_p <= '0;
         end else begin
            vld_p[0] <= vld_in & ~flush;
            for (int i = 1; i < DEPTH; i++)
               vld_p[i] <= vld_p[i-1] & ~flush;
         end
      end

      // Gold data needs no reset: it is only looked at when its valid bit is set.
      always_ff @(posedge clk) begin
         gold_p[0] <= gold_in;
         for (int i = 1; i < DEPTH; i++)
            gold_p[i] <= gold_p[i-1];
      end

      assign vld_out  = vld_p[DEPTH-1];
      assign gold_out = gold_p[DEPTH-1];
   end

endmodule

// File: rtl/miter_seq_monitor.sv
// Aligns gold to the gate latency, compares with X-tolerant gold, keeps run statistics.
// Optional MITER_DEF_CHECK_EN: any X/Z bit on gate_sum makes the aligned sample a mismatch.
module miter_seq_monitor
   import miter_mon_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int GATE_LAT = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] n_samples,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] gold_sum,
   input  logic [WIDTH-1:0] gate_sum,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] first_idx,
   output logic [WIDTH-1:0] first_gold,
   output logic [WIDTH-1:0] first_gate
);

   localparam int ALIGN_DEPTH = (GATE_LAT > MAX_GATE_LAT) ? MAX_GATE_LAT :
                                (GATE_LAT < 0) ? 0 : GATE_LAT;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // An X on gold is a don't-care; every other gold bit must match the gate exactly.
   function automatic logic sample_ok(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] t);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < WIDTH; i++)
         if (!((g[i] === 1'bx) || (g[i] === t[i])))
            ok = 1'b0;
`ifdef MITER_DEF_CHECK_EN
      if ((^t) === 1'bx)
         ok = 1'b0;
`endif
      return ok;
   endfunction

   mon_state_e       state;
   logic [CNT_W-1:0] target;
   logic             vld_p0;
   logic [WIDTH-1:0] gold_p0;
   logic             sample_hit;
   logic             mism_p0;
   logic [CNT_W-1:0] cnt_nx;
   logic             run_end;

   miter_align_pipe #(
      .WIDTH (WIDTH),
      .DEPTH (ALIGN_DEPTH)
   ) u_align (
      .clk      (clk),
      .reset    (reset),
      .flush    (start),
      .vld_in   (valid_in),
      .gold_in  (gold_sum),
      .vld_out  (vld_p0),
      .gold_out (gold_p0)
   );

   // p0: aligned gold/valid meet the current gate sample
   assign sample_hit = (state == RUN) && vld_p0 && !start;
   assign mism_p0    = !sample_ok(gold_p0, gate_sum);
   assign cnt_nx     = sat_inc(sample_cnt);
   assign run_end    = (target != '0) && (cnt_nx == target);
   assign busy       = (state == RUN);

   // p1: statistics and verdict registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         target       <= '0;
         done         <= 1'b0;
         fail         <= 1'b0;
         sample_cnt   <= '0;
         mismatch_cnt <= '0;
         first_idx    <= '0;
         first_gold   <= '0;
         first_gate   <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            state        <= RUN;
            target       <= n_samples;
            fail         <= 1'b0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_gold   <= '0;
            first_gate   <= '0;
         end else if (sample_hit) begin
            sample_cnt <= cnt_nx;
            if (mism_p0) begin
               mismatch_cnt <= sat_inc(mismatch_cnt);
               fail         <= 1'b1;
               if (!fail) begin
                  first_idx  <= sample_cnt;
                  first_gold <= gold_p0;
                  first_gate <= gate_sum;
               end
            end
            // The verdict includes the final sample's own compare result.
            if (run_end) begin
               state <= (fail || mism_p0) ? FAIL : PASS;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_miter_seq_monitor.sv
// Randomized and directed bench: four monitor variants share stimulus, each tracked by a history-based model.
module tb_miter_seq_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        valid_in;
   logic [15:0] n_samples;
   logic [3:0]  gold_sum;
   logic [3:0]  gate_sum;

   always #5 clk = ~clk;

   logic        busy_w [3];
   logic        done_w [3];
   logic        fail_w [3];
   logic [15:0] sc_w [3];
   logic [15:0] mc_w [3];
   logic [15:0] fi_w [3];
   logic [3:0]  fg_w [3];
   logic [3:0]  ft_w [3];
   logic        ds_busy, ds_done, ds_fail;
   logic [3:0]  ds_sc, ds_mc, ds_fi;
   logic [0:0]  ds_fg, ds_ft;

   miter_seq_monitor #(.WIDTH(4), .GATE_LAT(0), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .start(start), .n_samples(n_samples), .valid_in(valid_in),
      .gold_sum(gold_sum), .gate_sum(gate_sum), .busy(busy_w[0]), .done(done_w[0]),
      .fail(fail_w[0]), .sample_cnt(sc_w[0]), .mismatch_cnt(mc_w[0]), .first_idx(fi_w[0]),
      .first_gold(fg_w[0]), .first_gate(ft_w[0]));

   miter_seq_monitor #(.WIDTH(4), .GATE_LAT(1), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .start(start), .n_samples(n_samples), .valid_in(valid_in),
      .gold_sum(gold_sum), .gate_sum(gate_sum), .busy(busy_w[1]), .done(done_w[1]),
      .fail(fail_w[1]), .sample_cnt(sc_w[1]), .mismatch_cnt(mc_w[1]), .first_idx(fi_w[1]),
      .first_gold(fg_w[1]), .first_gate(ft_w[1]));

   miter_seq_monitor #(.WIDTH(4), .GATE_LAT(2), .CNT_W(16)) dut2 (
      .clk(clk), .reset(reset), .start(start), .n_samples(n_samples), .valid_in(valid_in),
      .gold_sum(gold_sum), .gate_sum(gate_sum), .busy(busy_w[2]), .done(done_w[2]),
      .fail(fail_w[2]), .sample_cnt(sc_w[2]), .mismatch_cnt(mc_w[2]), .first_idx(fi_w[2]),
      .first_gold(fg_w[2]), .first_gate(ft_w[2]));

   miter_seq_monitor #(.WIDTH(1), .GATE_LAT(0), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .start(start), .n_samples(n_samples[3:0]), .valid_in(valid_in),
      .gold_sum(gold_sum[0:0]), .gate_sum(gate_sum[0:0]), .busy(ds_busy), .done(ds_done),
      .fail(ds_fail), .sample_cnt(ds_sc), .mismatch_cnt(ds_mc), .first_idx(ds_fi),
      .first_gold(ds_fg), .first_gate(ds_ft));

   logic [58:0] obs [4];
   assign obs[0] = {busy_w[0], done_w[0], fail_w[0], sc_w[0], mc_w[0], fi_w[0], fg_w[0], ft_w[0]};
   assign obs[1] = {busy_w[1], done_w[1], fail_w[1], sc_w[1], mc_w[1], fi_w[1], fg_w[1], ft_w[1]};
   assign obs[2] = {busy_w[2], done_w[2], fail_w[2], sc_w[2], mc_w[2], fi_w[2], fg_w[2], ft_w[2]};
   assign obs[3] = {ds_busy, ds_done, ds_fail, 12'd0, ds_sc, 12'd0, ds_mc, 12'd0, ds_fi,
                    3'd0, ds_fg, 3'd0, ds_ft};

   // Reference model: every input sample ever driven is kept; the aligned gold is just
   // the entry GATE_LAT cycles back, usable only if it arrived after the last start/reset.
   int          lat_k  [4] = '{0, 1, 2, 0};
   int          w_k    [4] = '{4, 4, 4, 1};
   int          cmax_k [4] = '{65535, 65535, 65535, 15};
   bit          m_busy [4];
   bit          m_done [4];
   bit          m_fail [4];
   int          m_sc   [4];
   int          m_mc   [4];
   int          m_fidx [4];
   int          m_tgt  [4];
   logic [3:0]  m_fg   [4];
   logic [3:0]  m_ft   [4];
   logic        hv [$];
   logic [3:0]  hg [$];
   int          flush_t = -1;
   int          n_tests = 0;
   int          n_fail = 0;

   function automatic logic [3:0] msk(input logic [3:0] v, input int w);
      return (w == 4) ? v : {3'b000, v[0]};
   endfunction

   function automatic logic [58:0] exp_vec(input int k);
      return {m_busy[k], m_done[k], m_fail[k], m_sc[k][15:0], m_mc[k][15:0], m_fidx[k][15:0],
              m_fg[k], m_ft[k]};
   endfunction

   task automatic model_clear_k(input int k);
      m_busy[k] = 1'b0; m_done[k] = 1'b0; m_fail[k] = 1'b0;
      m_sc[k] = 0; m_mc[k] = 0; m_fidx[k] = 0; m_tgt[k] = 0;
      m_fg[k] = 4'd0; m_ft[k] = 4'd0;
   endtask

   task automatic model_step(input int t);
      for (int k = 0; k < 4; k++) begin
         int c;
         logic [3:0] g, gt;
         bit ok;
         int prev;
         m_done[k] = 1'b0;
         c = t - lat_k[k];
         if (start) begin
            model_clear_k(k);
            m_busy[k] = 1'b1;
            m_tgt[k]  = int'(n_samples) & cmax_k[k];
         end else if (m_busy[k] && c >= 0 && c > flush_t && hv[c] === 1'b1) begin
            g  = msk(hg[c], w_k[k]);
            gt = msk(gate_sum, w_k[k]);
            ok = 1'b1;
            for (int i = 0; i < w_k[k]; i++)
               if (!((g[i] === 1'bx) || (g[i] === gt[i]))) ok = 1'b0;
`ifdef MITER_DEF_CHECK_EN
            if ((^gt) === 1'bx) ok = 1'b0;
`endif
            prev = m_sc[k];
            if (m_sc[k] < cmax_k[k]) m_sc[k]++;
            if (!ok) begin
               if (!m_fail[k]) begin
                  m_fidx[k] = prev; m_fg[k] = g; m_ft[k] = gt;
               end
               if (m_mc[k] < cmax_k[k]) m_mc[k]++;
               m_fail[k] = 1'b1;
            end
            if (m_tgt[k] != 0 && m_sc[k] == m_tgt[k]) begin
               m_busy[k] = 1'b0;
               m_done[k] = 1'b1;
            end
         end
      end
      if (start) flush_t = t;
   endtask

   // One clock: log inputs, advance the model, return at the following falling edge.
   task automatic tick(input bit rst_edge);
      int t;
      t = hv.size();
      hv.push_back(rst_edge ? 1'b0 : valid_in);
      hg.push_back(gold_sum);
      if (rst_edge) begin
         for (int k = 0; k < 4; k++) model_clear_k(k);
         flush_t = t;
      end else begin
         model_step(t);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_start(input int n);
      start = 1'b1; n_samples = 16'(n);
      valid_in = 1'($urandom_range(0, 1)); gold_sum = 4'($urandom); gate_sum = 4'($urandom);
      tick(1'b0);
      start = 1'b0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (obs[k] !== 59'd0) begin
            n_fail++;
            $display("FAIL reset dut%0d got %h required 0", k, obs[k]);
         end
      end
   endtask

   task automatic test_basic_pass();
      int pulses = 0;
      do_start(4);
      for (int s = 0; s < 6; s++) begin
         valid_in = (s < 4); gold_sum = 4'($urandom); gate_sum = gold_sum;
         tick(1'b0);
         if (done_w[0] === 1'b1) pulses++;
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL basic dut%0d s%0d got %h required %h", k, s, obs[k], exp_vec(k));
            end
         end
      end
      n_tests++;
      if (pulses !== 1 || fail_w[0] !== 1'b0 || sc_w[0] !== 16'd4 || mc_w[0] !== 16'd0
          || busy_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_final pulses=%0d fail=%b sc=%0d mc=%0d busy=%b required 1 0 4 0 0",
                  pulses, fail_w[0], sc_w[0], mc_w[0], busy_w[0]);
      end
   endtask

   task automatic test_x_gold();
      logic [3:0] gl [3];
      logic [3:0] gt [3];
      gl[0] = 4'bxxxx; gt[0] = 4'b0000;
      gl[1] = 4'bxxxx; gt[1] = 4'b1111;
      gl[2] = 4'b0000; gt[2] = 4'bxxxx;
      do_start(3);
      for (int s = 0; s < 3; s++) begin
         valid_in = 1'b1; gold_sum = gl[s]; gate_sum = gt[s];
         tick(1'b0);
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL xgold dut%0d s%0d got %h required %h", k, s, obs[k], exp_vec(k));
            end
         end
      end
   endtask

   task automatic test_latency();
      logic [3:0] last = 4'd0;
      do_start(10);
      for (int s = 0; s < 12; s++) begin
         int t;
         t = hg.size();
         valid_in = 1'b1;
         gold_sum = last + 4'($urandom_range(1, 15));
         last = gold_sum;
         gate_sum = hg[t-2];
         tick(1'b0);
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL latency dut%0d s%0d got %h required %h", k, s, obs[k], exp_vec(k));
            end
         end
      end
      n_tests++;
      if (fail_w[2] !== 1'b0 || mc_w[2] !== 16'd0 || sc_w[2] !== 16'd10 || fail_w[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_final lat2 fail=%b mc=%0d sc=%0d lat1 fail=%b required 0 0 10 1",
                  fail_w[2], mc_w[2], sc_w[2], fail_w[1]);
      end
   endtask

   task automatic test_first_capture();
      logic [3:0] g3 = 4'd0;
      logic [3:0] t3 = 4'd0;
      do_start(8);
      for (int s = 1; s <= 8; s++) begin
         valid_in = 1'b1; gold_sum = 4'($urandom);
         gate_sum = (s == 3 || s == 6) ? ~gold_sum : gold_sum;
         if (s == 3) begin g3 = gold_sum; t3 = gate_sum; end
         tick(1'b0);
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL first dut%0d s%0d got %h required %h", k, s, obs[k], exp_vec(k));
            end
         end
      end
      n_tests++;
      if (done_w[0] !== 1'b1 || fail_w[0] !== 1'b1 || fi_w[0] !== 16'd2 || mc_w[0] !== 16'd2
          || sc_w[0] !== 16'd8 || busy_w[0] !== 1'b0 || fg_w[0] !== g3 || ft_w[0] !== t3) begin
         n_fail++;
         $display("FAIL first_final done=%b fail=%b idx=%0d mc=%0d sc=%0d busy=%b g=%h t=%h required 1 1 2 2 8 0 %h %h",
                  done_w[0], fail_w[0], fi_w[0], mc_w[0], sc_w[0], busy_w[0], fg_w[0], ft_w[0], g3, t3);
      end
   endtask

   task automatic test_saturate();
      int pulses = 0;
      do_start(0);
      for (int s = 0; s < 20; s++) begin
         valid_in = 1'b1; gold_sum = 4'($urandom); gate_sum = ~gold_sum;
         tick(1'b0);
         if (ds_done === 1'b1) pulses++;
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL sat dut%0d s%0d got %h required %h", k, s, obs[k], exp_vec(k));
            end
         end
      end
      n_tests++;
      if (ds_mc !== 4'd15 || ds_sc !== 4'd15 || pulses !== 0 || ds_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_final mc=%0d sc=%0d pulses=%0d busy=%b required 15 15 0 1",
                  ds_mc, ds_sc, pulses, ds_busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int pulses = 0;
      do_start(8);
      for (int s = 0; s < 3; s++) begin
         valid_in = 1'b1; gold_sum = 4'($urandom); gate_sum = ~gold_sum;
         tick(1'b0);
      end
      reset = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (obs[k] !== 59'd0) begin
            n_fail++;
            $display("FAIL async_reset dut%0d got %h required 0", k, obs[k]);
         end
      end
      valid_in = 1'b1;
      tick(1'b1);
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (obs[k] !== 59'd0) begin
            n_fail++;
            $display("FAIL reset_hold dut%0d got %h required 0", k, obs[k]);
         end
      end
      reset = 1'b0;
      do_start(5);
      for (int s = 0; s < 8; s++) begin
         int t;
         t = hg.size();
         valid_in = 1'b1; gold_sum = 4'($urandom); gate_sum = hg[t-2];
         tick(1'b0);
         if (done_w[2] === 1'b1) pulses++;
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL rerun dut%0d s%0d got %h required %h", k, s, obs[k], exp_vec(k));
            end
         end
      end
      n_tests++;
      if (fail_w[2] !== 1'b0 || sc_w[2] !== 16'd5 || pulses !== 1) begin
         n_fail++;
         $display("FAIL rerun_final fail=%b sc=%0d pulses=%0d required 0 5 1", fail_w[2], sc_w[2], pulses);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         do_start($urandom_range(0, 12));
         for (int s = 0; s < int'($urandom_range(4, 16)); s++) begin
            int t;
            int sel;
            logic [3:0] src;
            t = hg.size();
            valid_in = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++)
               gold_sum[i] = ($urandom_range(0, 9) == 0) ? 1'bx : 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            src = (sel == 0) ? gold_sum : (sel == 1) ? hg[t-1] : (sel == 2) ? hg[t-2] : 4'($urandom);
            for (int i = 0; i < 4; i++)
               gate_sum[i] = (src[i] === 1'b1) ? 1'b1 : (src[i] === 1'b0) ? 1'b0 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 14) == 0) gate_sum[0] = 1'bx;
            tick(1'b0);
            for (int k = 0; k < 4; k++) begin
               n_tests++;
               if (obs[k] !== exp_vec(k)) begin
                  n_fail++;
                  $display("FAIL random dut%0d r%0d s%0d got %h required %h", k, r, s, obs[k], exp_vec(k));
               end
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; valid_in = 1'b0; n_samples = 16'd0;
      gold_sum = 4'd0; gate_sum = 4'd0;
      for (int k = 0; k < 4; k++) model_clear_k(k);
      tick(1'b1);
      tick(1'b1);
      reset = 1'b0;
      test_reset();
      test_basic_pass();
      test_x_gold();
      test_latency();
      test_first_capture();
      test_saturate();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
